// File: rtl/rob_pkg.sv
// rob_pkg: shared defaults and field widths for the reorder buffer.
// Imported by the bus interface, the top and the commit selector.
package rob_pkg;

    localparam int ROB_DEPTH    = 16;
    localparam int ROB_COMMIT_W = 2;
    localparam int ROB_XLEN     = 32;
    localparam int ROB_ARCH_W   = 5;
    localparam int ROB_PHYS_W   = 6;

    // Entry index width for a given number of entries.
    function automatic int rob_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/reorder_buffer_v2_if.sv
// reorder_buffer_v2_if: alloc / CDB / flush inputs and commit / status
// outputs of the ROB. master = front end + execute side, slave = ROB.
interface reorder_buffer_v2_if
    import rob_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int COMMIT_W = ROB_COMMIT_W,
    parameter int XLEN     = ROB_XLEN,
    parameter int ARCH_W   = ROB_ARCH_W,
    parameter int PHYS_W   = ROB_PHYS_W
);
    localparam int IDX_W = rob_idx_w(DEPTH);

    logic                       alloc_valid;
    logic                       alloc_ready;
    logic [ARCH_W-1:0]          alloc_dest_arch;
    logic [PHYS_W-1:0]          alloc_dest_phys;
    logic [IDX_W-1:0]           alloc_idx;

    logic                       cdb_valid;
    logic [PHYS_W-1:0]          cdb_tag;
    logic [XLEN-1:0]            cdb_value;
    logic                       cdb_exc;

    logic                       flush_valid;
    logic [IDX_W-1:0]           flush_idx;

    logic [COMMIT_W-1:0]        commit_valid;
    logic [COMMIT_W*ARCH_W-1:0] commit_arch_addr;
    logic [COMMIT_W*PHYS_W-1:0] commit_phys;
    logic [COMMIT_W*XLEN-1:0]   commit_data;

    logic                       exc_valid;
    logic [IDX_W-1:0]           exc_idx;
    logic [IDX_W:0]             count;
    logic                       full;
    logic                       empty;

    modport master (
        output alloc_valid, alloc_dest_arch, alloc_dest_phys,
        output cdb_valid, cdb_tag, cdb_value, cdb_exc,
        output flush_valid, flush_idx,
        input  alloc_ready, alloc_idx,
        input  commit_valid, commit_arch_addr, commit_phys, commit_data,
        input  exc_valid, exc_idx, count, full, empty
    );

    modport slave (
        input  alloc_valid, alloc_dest_arch, alloc_dest_phys,
        input  cdb_valid, cdb_tag, cdb_value, cdb_exc,
        input  flush_valid, flush_idx,
        output alloc_ready, alloc_idx,
        output commit_valid, commit_arch_addr, commit_phys, commit_data,
        output exc_valid, exc_idx, count, full, empty
    );

endinterface

// File: rtl/rob_commit_select.sv
// rob_commit_select: in-order retire lane selection from the head.
// In: head_idx, ok (live/ready/no-exc), bad (live/ready/exc). Out: lane_vld, adv, exc_hit.
module rob_commit_select
    import rob_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int COMMIT_W = ROB_COMMIT_W,
    parameter int IDX_W    = rob_idx_w(DEPTH)
) (
    input  logic [IDX_W-1:0]    head_idx,
    input  logic [DEPTH-1:0]    ok,
    input  logic [DEPTH-1:0]    bad,
    output logic [COMMIT_W-1:0] lane_vld,
    output logic [IDX_W:0]      adv,
    output logic                exc_hit
);

    assign exc_hit = bad[head_idx];

    // A lane retires only if every older lane retires too; an exception
    // entry is never "ok", so it stops the chain at its own lane.
    always_comb begin
        logic             run;
        logic [IDX_W-1:0] idx;
        run      = 1'b1;
        idx      = '0;
        lane_vld = '0;
        adv      = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            idx         = head_idx + IDX_W'(k);
            run         = run && ok[idx];
            lane_vld[k] = run;
            if (run) begin
                adv = adv + (IDX_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_v2.sv
// reorder_buffer_v2: circular ROB with CDB wakeup, in-order multi-lane commit,
// precise exceptions and mispredict flush. Ports: clk, reset, bus (slave).
module reorder_buffer_v2
    import rob_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int COMMIT_W = ROB_COMMIT_W,
    parameter int XLEN     = ROB_XLEN,
    parameter int ARCH_W   = ROB_ARCH_W,
    parameter int PHYS_W   = ROB_PHYS_W
) (
    input  logic               clk,
    input  logic               reset,
    reorder_buffer_v2_if.slave bus
);

    localparam int IDX_W = rob_idx_w(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [DEPTH-1:0]    vld_q;
    logic [DEPTH-1:0]    rdy_q;
    logic [DEPTH-1:0]    exc_q;
    logic [ARCH_W-1:0]   arch_q [DEPTH];
    logic [PHYS_W-1:0]   phys_q [DEPTH];
    logic [XLEN-1:0]     data_q [DEPTH];

    logic [PTR_W-1:0]    cnt;
    logic [IDX_W-1:0]    head_idx;
    logic [IDX_W-1:0]    tail_idx;
    logic [IDX_W-1:0]    f_off;
    logic                is_full;
    logic                flush_go;
    logic                alloc_go;
    logic                exc_hit;
    logic [DEPTH-1:0]    live;
    logic [DEPTH-1:0]    survive;
    logic [DEPTH-1:0]    ok;
    logic [DEPTH-1:0]    bad;
    logic [DEPTH-1:0]    done;
    logic [DEPTH-1:0]    hit;
    logic [DEPTH-1:0]    alloc_mask;
    logic [COMMIT_W-1:0] lane_vld;
    logic [PTR_W-1:0]    adv;

    assign cnt      = tail_q - head_q;
    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign is_full  = (cnt == PTR_W'(DEPTH));
    assign f_off    = bus.flush_idx - head_idx;

    // Liveness is the head..tail window; the flush keeps entries no
    // younger than flush_idx (distance from head <= its own distance).
    always_comb begin
        logic [IDX_W-1:0] off;
        off      = '0;
        live     = '0;
        survive  = '0;
        flush_go = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off     = IDX_W'(i) - head_idx;
            live[i] = vld_q[i] && ({1'b0, off} < cnt);
        end
        flush_go = bus.flush_valid && live[bus.flush_idx];
        for (int i = 0; i < DEPTH; i++) begin
            off        = IDX_W'(i) - head_idx;
            survive[i] = live[i] && (!flush_go || (off <= f_off));
        end
    end

    assign ok  = survive & rdy_q & ~exc_q;
    assign bad = live & rdy_q & exc_q;

    rob_commit_select #(
        .DEPTH    (DEPTH),
        .COMMIT_W (COMMIT_W),
        .IDX_W    (IDX_W)
    ) u_sel (
        .head_idx (head_idx),
        .ok       (ok),
        .bad      (bad),
        .lane_vld (lane_vld),
        .adv      (adv),
        .exc_hit  (exc_hit)
    );

    assign alloc_go = bus.alloc_valid && bus.alloc_ready && !exc_hit;

    always_comb begin
        done       = '0;
        alloc_mask = '0;
        hit        = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (lane_vld[k]) begin
                done[head_idx + IDX_W'(k)] = 1'b1;
            end
        end
        if (alloc_go) begin
            alloc_mask[tail_idx] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = bus.cdb_valid && survive[i] && !rdy_q[i]
                  && (phys_q[i] == bus.cdb_tag);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            vld_q  <= '0;
            rdy_q  <= '0;
            exc_q  <= '0;
        end else if (exc_hit) begin
            head_q <= tail_q;
            vld_q  <= '0;
            rdy_q  <= '0;
            exc_q  <= '0;
        end else begin
            head_q <= head_q + adv;
            if (flush_go) begin
                tail_q <= head_q + PTR_W'(f_off) + PTR_W'(1);
            end else if (alloc_go) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            vld_q <= (survive & ~done) | alloc_mask;
            rdy_q <= (rdy_q | hit) & ~alloc_mask;
            exc_q <= ((exc_q & ~hit) | (hit & {DEPTH{bus.cdb_exc}}))
                   & ~alloc_mask;
        end
    end

    // Payload needs no reset: it is only observed through valid bits.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                data_q[i] <= bus.cdb_value;
            end
        end
        if (alloc_go) begin
            arch_q[tail_idx] <= bus.alloc_dest_arch;
            phys_q[tail_idx] <= bus.alloc_dest_phys;
        end
    end

    assign bus.alloc_ready  = !is_full && !bus.flush_valid;
    assign bus.alloc_idx    = tail_idx;
    assign bus.count        = cnt;
    assign bus.full         = is_full;
    assign bus.empty        = (cnt == '0);
    assign bus.commit_valid = lane_vld;
    assign bus.exc_valid    = exc_hit;
    assign bus.exc_idx      = exc_hit ? head_idx : '0;

    always_comb begin
        logic [IDX_W-1:0] idx;
        idx                  = '0;
        bus.commit_arch_addr = '0;
        bus.commit_phys      = '0;
        bus.commit_data      = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            idx = head_idx + IDX_W'(k);
            if (lane_vld[k]) begin
                bus.commit_arch_addr[k*ARCH_W +: ARCH_W] = arch_q[idx];
                bus.commit_phys[k*PHYS_W +: PHYS_W]      = phys_q[idx];
                bus.commit_data[k*XLEN +: XLEN]          = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_v2.sv
// tb_reorder_buffer_v2: directed scenarios plus random traffic against a
// queue-based ROB model; every cycle's outputs are compared to the model.
module tb_reorder_buffer_v2;
    import rob_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = 2;
    localparam int XL    = 32;
    localparam int AW    = 5;
    localparam int PHW   = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reorder_buffer_v2_if #(
        .DEPTH(DEPTH), .COMMIT_W(CW), .XLEN(XL), .ARCH_W(AW), .PHYS_W(PHW)
    ) bus ();

    reorder_buffer_v2 #(
        .DEPTH(DEPTH), .COMMIT_W(CW), .XLEN(XL), .ARCH_W(AW), .PHYS_W(PHW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          arch;
        int          phys;
        bit          rdy;
        bit          exc;
        logic [XL-1:0] data;
    } ent_t;

    ent_t q[$];
    int   head    = 0;
    int   vec     = 0;
    int   bad     = 0;
    int   fpos    = 0;
    int   ncommit = 0;
    bit   fgo     = 0;
    bit   excp    = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.alloc_valid     = 1'b0;
        bus.alloc_dest_arch = '0;
        bus.alloc_dest_phys = '0;
        bus.cdb_valid       = 1'b0;
        bus.cdb_tag         = '0;
        bus.cdb_value       = '0;
        bus.cdb_exc         = 1'b0;
        bus.flush_valid     = 1'b0;
        bus.flush_idx       = '0;
    endtask

    task automatic alloc(input int a, input int p);
        idle();
        bus.alloc_valid     = 1'b1;
        bus.alloc_dest_arch = AW'(a);
        bus.alloc_dest_phys = PHW'(p);
    endtask

    task automatic cdb(input int t, input int v, input bit e);
        idle();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = PHW'(t);
        bus.cdb_value = XL'(v);
        bus.cdb_exc   = e;
    endtask

    // Expected outputs straight from the ordered entry list.
    task automatic check_outputs();
        int sz;
        bit run;
        logic [CW-1:0]     ev;
        logic [CW*AW-1:0]  ea;
        logic [CW*PHW-1:0] ep;
        logic [CW*XL-1:0]  ed;
        sz   = q.size();
        fpos = (int'(bus.flush_idx) - head % DEPTH + DEPTH) % DEPTH;
        fgo  = bus.flush_valid && (fpos < sz);
        excp = (sz > 0) && q[0].rdy && q[0].exc;
        ev = '0; ea = '0; ep = '0; ed = '0;
        ncommit = 0;
        run = 1'b1;
        for (int k = 0; k < CW; k++) begin
            run = run && (k < sz) && (!fgo || k <= fpos);
            if (run) run = q[k].rdy && !q[k].exc;
            if (run) begin
                ev[k]              = 1'b1;
                ea[k*AW +: AW]     = AW'(q[k].arch);
                ep[k*PHW +: PHW]   = PHW'(q[k].phys);
                ed[k*XL +: XL]     = q[k].data;
                ncommit++;
            end
        end
        chk("count", bus.count, sz);
        chk("full", bus.full, sz == DEPTH);
        chk("empty", bus.empty, sz == 0);
        chk("alloc_ready", bus.alloc_ready, (sz < DEPTH) && !bus.flush_valid);
        chk("alloc_idx", bus.alloc_idx, (head + sz) % DEPTH);
        chk("exc_valid", bus.exc_valid, excp);
        chk("exc_idx", bus.exc_idx, excp ? head % DEPTH : 0);
        chk("commit_valid", bus.commit_valid, ev);
        chk("commit_arch", bus.commit_arch_addr, ea);
        chk("commit_phys", bus.commit_phys, ep);
        chk("commit_data", bus.commit_data, ed);
    endtask

    task automatic model_step();
        int sz;
        sz = q.size();
        if (excp) begin
            head = (head + sz) % (2*DEPTH);
            q.delete();
        end else begin
            if (fgo) begin
                while (q.size() > fpos + 1) void'(q.pop_back());
            end
            if (bus.cdb_valid) begin
                foreach (q[i]) begin
                    if (!q[i].rdy && q[i].phys == int'(bus.cdb_tag)) begin
                        q[i].rdy  = 1'b1;
                        q[i].exc  = bus.cdb_exc;
                        q[i].data = bus.cdb_value;
                    end
                end
            end
            repeat (ncommit) void'(q.pop_front());
            head = (head + ncommit) % (2*DEPTH);
            if (bus.alloc_valid && sz < DEPTH && !bus.flush_valid) begin
                q.push_back('{arch: int'(bus.alloc_dest_arch),
                              phys: int'(bus.alloc_dest_phys),
                              rdy: 1'b0, exc: 1'b0, data: '0});
            end
        end
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic fin();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        fin();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        head = 0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_alloc_ready", bus.alloc_ready, 1);
        chk("rst_commit_valid", bus.commit_valid, 0);
        chk("rst_exc_valid", bus.exc_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill, reject at full, wake in reverse, drain two per cycle.
        for (int i = 0; i < 16; i++) begin
            alloc(i + 1, 10 + i);
            cycle();
        end
        idle();
        settle();
        chk("fill_count", bus.count, 16);
        chk("fill_full", bus.full, 1);
        chk("fill_alloc_ready", bus.alloc_ready, 0);
        fin();
        for (int i = 15; i >= 0; i--) begin
            cdb(10 + i, 1000 + i, 1'b0);
            if (i == 15) bus.alloc_valid = 1'b1;
            cycle();
        end
        idle();
        for (int c = 0; c < 8; c++) begin
            settle();
            chk("drain_two_lanes", bus.commit_valid, 2'b11);
            fin();
        end
        settle();
        chk("drain_empty", bus.empty, 1);
        fin();

        // Out-of-order completion.
        for (int i = 0; i < 3; i++) begin
            alloc(i + 1, 10 + i);
            cycle();
        end
        cdb(12, 789, 1'b0);
        cycle();
        cdb(11, 456, 1'b0);
        settle();
        chk("ooo_hold1", bus.commit_valid, 0);
        fin();
        cdb(10, 123, 1'b0);
        settle();
        chk("ooo_hold2", bus.commit_valid, 0);
        fin();
        idle();
        settle();
        chk("ooo_valid2", bus.commit_valid, 2'b11);
        chk("ooo_arch2", bus.commit_arch_addr, {5'd2, 5'd1});
        chk("ooo_data2", bus.commit_data, {32'd456, 32'd123});
        fin();
        settle();
        chk("ooo_valid1", bus.commit_valid, 2'b01);
        chk("ooo_arch1", bus.commit_arch_addr, {5'd0, 5'd3});
        chk("ooo_data1", bus.commit_data, {32'd0, 32'd789});
        fin();

        // Mispredict flush.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(i + 1, 20 + i);
            settle();
            chk("mp_alloc_idx", bus.alloc_idx, i);
            fin();
        end
        idle();
        bus.flush_valid = 1'b1;
        bus.flush_idx   = 4'd1;
        settle();
        chk("mp_flush_ready", bus.alloc_ready, 0);
        fin();
        idle();
        settle();
        chk("mp_count", bus.count, 2);
        chk("mp_tail", bus.alloc_idx, 2);
        fin();
        cdb(23, 99, 1'b0);
        cycle();
        idle();
        settle();
        chk("mp_stale_cdb_count", bus.count, 2);
        chk("mp_stale_cdb_commit", bus.commit_valid, 0);
        fin();
        alloc(9, 33);
        settle();
        chk("mp_next_idx", bus.alloc_idx, 2);
        fin();

        // Exception behind a completed instruction.
        do_reset();
        alloc(7, 30);
        cycle();
        alloc(8, 31);
        cycle();
        cdb(30, 5, 1'b0);
        cycle();
        cdb(31, 6, 1'b1);
        settle();
        chk("exc_commit_lane0", bus.commit_valid, 2'b01);
        chk("exc_commit_arch", bus.commit_arch_addr, {5'd0, 5'd7});
        fin();
        idle();
        settle();
        chk("exc_valid", bus.exc_valid, 1);
        chk("exc_idx", bus.exc_idx, 1);
        chk("exc_no_commit", bus.commit_valid, 0);
        fin();
        settle();
        chk("exc_count", bus.count, 0);
        fin();

        // Index wrap.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            alloc(i % 32, i % 64);
            settle();
            chk("wrap_alloc_idx", bus.alloc_idx, i % 16);
            chk("wrap_not_full", bus.full, 0);
            fin();
            cdb(i % 64, i, 1'b0);
            cycle();
            idle();
            cycle();
        end

        // Asynchronous reset with a commit pending.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(i, 40 + i);
            cycle();
        end
        for (int i = 4; i >= 0; i--) begin
            cdb(40 + i, 500 + i, 1'b0);
            cycle();
        end
        idle();
        settle();
        chk("ar_pending", bus.commit_valid, 2'b11);
        reset = 1'b1;
        #1;
        chk("ar_commit_valid", bus.commit_valid, 0);
        chk("ar_count", bus.count, 0);
        q.delete();
        head = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        alloc(3, 3);
        settle();
        chk("ar_first_idx", bus.alloc_idx, 0);
        fin();

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            idle();
            if ($urandom_range(0, 9) < 6) begin
                bus.alloc_valid     = 1'b1;
                bus.alloc_dest_arch = AW'($urandom_range(0, 31));
                bus.alloc_dest_phys = PHW'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1) == 1) begin
                bus.cdb_valid = 1'b1;
                if (q.size() > 0 && $urandom_range(0, 4) != 0)
                    bus.cdb_tag = PHW'(q[$urandom_range(0, q.size() - 1)].phys);
                else
                    bus.cdb_tag = PHW'($urandom_range(0, 63));
                bus.cdb_value = $urandom;
                bus.cdb_exc   = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 24) == 0) begin
                bus.flush_valid = 1'b1;
                bus.flush_idx   = 4'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer_v2.md
REORDER_BUFFER_V2 -- requirements
Module: reorder_buffer_v2

Interface
REQ-001 Parameter DEPTH, default 16, meaning number of entries (power of 2, 4..64).
REQ-002 Parameter COMMIT_W, default 2, meaning retire lanes per cycle (1 or 2).
REQ-003 Parameter XLEN, default 32, meaning result width; ARCH_W default 5, meaning arch reg index width; PHYS_W default 6, meaning phys tag width; IDX_W = log2(DEPTH).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 alloc_valid  in  1; alloc_ready  out  1; alloc_dest_arch  in  ARCH_W; alloc_dest_phys  in  PHYS_W; alloc_idx  out  IDX_W (tail index given to the new entry).
REQ-007 cdb_valid  in  1; cdb_tag  in  PHYS_W; cdb_value  in  XLEN; cdb_exc  in  1 (result raised an exception).
REQ-008 flush_valid  in  1; flush_idx  in  IDX_W (youngest surviving entry after a branch mispredict).
REQ-009 commit_valid  out  COMMIT_W; commit_arch_addr  out  COMMIT_W*ARCH_W; commit_phys  out  COMMIT_W*PHYS_W; commit_data  out  COMMIT_W*XLEN (lane 0 in LSBs).
REQ-010 exc_valid  out  1; exc_idx  out  IDX_W; count  out  IDX_W+1; full  out  1; empty  out  1.

Function
REQ-011 Storage: circular buffer; head/tail pointers are IDX_W+1 bits wide with a wrap bit; full = (count==DEPTH); empty = (count==0).
REQ-012 Allocation: alloc_ready = !full && !flush_valid; a transfer occurs when alloc_valid && alloc_ready; the entry at tail is written {valid=1, ready=0, exc=0, arch, phys}; tail advances at the edge.
REQ-013 Allocation while full is dropped with no state change; a same-cycle commit does not free space for that cycle's allocation.
REQ-014 CDB: on cdb_valid, every live, not-ready entry whose phys equals cdb_tag latches value, exc and ready=1 at the edge; a tag matching no entry is ignored.
REQ-015 Commit is combinational from registered state: lane 0 valid iff head is live, ready and exc=0; lane k valid iff lane k-1 valid and entry head+k is live, ready and exc=0; head advances by the number of valid lanes at the edge.
REQ-016 Latency: a CDB write at edge N produces commit_valid during cycle N..N+1 and retirement at edge N+1.
REQ-017 Exception: if head is live, ready and exc=1, then exc_valid=1, exc_idx=head, all commit_valid=0; at the edge all entries are invalidated, with head=tail and count=0.
REQ-018 An exception entry at lane k>0 blocks lane k and younger lanes; it is raised when it reaches head.
REQ-019 Flush: on flush_valid with flush_idx live, tail = flush_idx+1 (wrap-aware) and entries younger than flush_idx are invalidated; a non-live flush_idx is ignored.
REQ-020 Same-cycle precedence: exception > flush > alloc. A CDB write applies only to entries that survive. Commits in the flush cycle proceed, including commit of flush_idx itself.
REQ-021 count = tail - head (IDX_W+1 bit subtraction); head and tail wrap modulo 2*DEPTH.
REQ-022 Outputs when not valid: commit_* data and exc_idx are 0.

Reset
REQ-023 Reset SHALL clear head, tail, all valid/ready/exc bits. In reset: count=0, empty=1, full=0, alloc_ready=1, commit_valid=0, exc_valid=0.
REQ-024 Reset asserted mid-operation discards all in-flight entries within the same cycle, with no commit pulse.

Structure
REQ-025 Package rob_pkg SHALL hold the default parameters and the entry field-width constants; the module port list references them.
REQ-026 One sub-module, rob_commit_select, SHALL compute lane validity and head advance; storage and pointers stay in the top.

Verification
REQ-027 Fill/drain: allocate 16 entries (arch 1..16, phys 10..25) -> full=1, alloc_ready=0. Then CDB all tags -> 2 commits per cycle and empty after 8 cycles.
REQ-028 Out-of-order completion: 3 allocs (phys 10,11,12); CDB 12=789, then 11=456, then 10=123 -> no commit until tag 10 arrives. On the next cycle lanes commit arch1=123 and arch2=456, then arch3=789.
REQ-029 Mispredict: 4 allocs idx 0..3; flush_idx=1 -> count=2 and tail=2. A later CDB for idx 3's tag has no effect; the next alloc_idx=2.
REQ-030 Exception: idx0 ready, idx1 CDB with cdb_exc=1 -> arch of idx0 commits; the next cycle exc_valid=1 with exc_idx=1, then count=0.
REQ-031 Wrap: allocate/commit 20 entries at DEPTH=16 -> alloc_idx sequence wraps 15->0, and full is never falsely set.
REQ-032 Async reset asserted with 5 entries live and commit pending -> commit_valid=0 immediately and count=0; first alloc after release gets alloc_idx=0.
